mult_share_ctrl: RTL and testbench
==================================

# mult_share_ctrl

Sequential controller that shares one instance of the combinational 4x4 `multiplier` between two requesters. Each requester issues operand pairs over a valid/ready handshake and receives its 8-bit product on its own result channel. The block arbitrates access, registers operands and product around the multiplier, and holds each result until its owner accepts it. It sits between the two client datapaths and the multiplier.

## Interface
- `W`, default 4: operand width. Fixed at 4 to match `multiplier`; any other value is unsupported.
- `PW`, default 8: product width, equal to 2*W.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operand pair.
- `req0_ready`  out  1  requester 0 operands are accepted this cycle.
- `req0_a`, `req0_b`  in  W  requester 0 operands.
- `res0_valid`  out  1  product for requester 0 is available.
- `res0_ready`  in  1  requester 0 consumes the product.
- `res0_p`  out  PW  product for requester 0.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `res1_valid`, `res1_ready`, `res1_p`: same as requester 0, for requester 1.
- `busy`  out  1  high in every state except IDLE.

## Operation
- The FSM has three states: IDLE, MUL and HOLD.
- IDLE:
  - The arbiter computes `grant` from `req0_valid`, `req1_valid` and `last`.
  - `reqX_ready` = (state==IDLE) && !rst && (grant==X) && `reqX_valid`.
  - On handshake, the block captures operands into `a_q`/`b_q`, sets `owner`=X and moves to MUL.
- MUL:
  - `multiplier` sees `a_q`/`b_q`.
  - The product is registered into `p_q` and the FSM moves to HOLD.
- HOLD:
  - `res<owner>_valid` is high and the other requester's `res_valid` is low.
  - On `res<owner>_ready`, the FSM goes to IDLE and `last` is set to `owner`.
- Arbitration:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester that is not `last` is granted (round-robin).
  - `last` resets to 1, so requester 0 wins the first tie.
- Both `res0_p` and `res1_p` drive `p_q`. Only the owner's valid qualifies it.
- Product arithmetic is unsigned, 4x4 to 8 bits, and never overflows (max 15*15=225).
- Requester rules:
  - Hold `valid` and operands stable until `ready`.
  - `valid` may drop only after a handshake.
- The block holds `p_q` and `res_valid` stable while `res_valid && !res_ready`.
- The block issues no new grant while a result is outstanding. There is one operation in flight at most.

## Timing
- Reset values:
  - State is IDLE.
  - `a_q`, `b_q`, `p_q` and `owner` are 0; `last` is 1.
  - All `reqX_ready` and `resX_valid` outputs are 0, `res0_p`/`res1_p` are 0 and `busy` is 0.
- Latency, with the handshake at cycle T:
  - State is MUL in T+1.
  - `res_valid` rises in T+2.
  - With `res_ready` already high, state is IDLE at T+3, and the next handshake can occur at T+3.
  - Minimum issue interval is 3 cycles.
- `ready` is combinational from state and valid. There are no other combinational input-to-output paths.
- Reset asserted in MUL or HOLD:
  - The in-flight operation is discarded with no result.
  - All outputs return to reset values on the next edge.
- A requester raising `valid` in the same cycle its previous result handshakes is not granted until the following cycle, because the FSM is still in HOLD.

## Configuration
- `MULT_SHARE_FIXED_PRIO_EN` defined: ties always go to requester 0. `last` is still maintained but is ignored.
- `MULT_SHARE_FIXED_PRIO_EN` undefined: round-robin arbitration as described under Operation.

## Structure
- Shared package/header `mult_share_pkg` holds:
  - The `W` and `PW` constants.
  - State encodings IDLE=2'd0, MUL=2'd1, HOLD=2'd2.
  - Requester index constants.
- Sub-modules:
  - The existing `multiplier` (port order P, A, B) is instantiated once.
  - The arbiter is one natural sub-module, `mult_share_arb`: inputs two valids, `last` and the macro; output `grant`.

## Test plan
- After reset, req0 presents a=3, b=5 with `res0_ready`=1:
  - `req0_ready` is high at T.
  - `res0_valid` is high at T+2 with `res0_p`=15.
  - `busy` falls at T+3.
- Both valid after reset, req0 7*8 and req1 15*15: req0 is granted first (product 56), then req1 (product 225). `res1_valid` never overlaps `res0_valid`.
- Both requesters valid continuously with results always accepted: grants alternate 0,1,0,1, with one handshake every 3 cycles.
- req1 9*9 with `res1_ready` held low for 5 cycles:
  - `res1_p`=81 stays stable.
  - `busy` stays high.
  - `req0_ready` stays 0 despite `req0_valid`.
- `rst` pulsed in the MUL cycle of 6*6: the next cycle has all valids 0 and `res_p`=0, and no result is ever emitted.
- With `MULT_SHARE_FIXED_PRIO_EN`, both requesters valid continuously: requester 0 is granted every time.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared constants for the mult_share_ctrl block: operand/product widths,
// controller state encoding and requester indices.
package mult_share_pkg;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mult_share_arb.sv
// Two-requester arbiter for mult_share_ctrl. Round-robin on ties by default;
// MULT_SHARE_FIXED_PRIO_EN makes requester 0 win every tie.
module mult_share_arb
  import mult_share_pkg::*;
(
  input  logic v0_i,
  input  logic v1_i,
  input  logic last_i,
  output logic grant_o
);

`ifdef MULT_SHARE_FIXED_PRIO_EN
  // History is still tracked by the controller but has no say here.
  logic unused_last;
  assign unused_last = last_i;

  always_comb begin
    grant_o = REQ0;
    if (!v0_i && v1_i) grant_o = REQ1;
  end
`else
  always_comb begin
    grant_o = REQ0;
    if (v0_i && v1_i)  grant_o = ~last_i;
    else if (v1_i)     grant_o = REQ1;
  end
`endif

endmodule

// File: rtl/multiplier.sv
// Combinational unsigned 4x4 -> 8 multiplier shared by mult_share_ctrl.
module multiplier (
  output logic [7:0] P,
  input  logic [3:0] A,
  input  logic [3:0] B
);

  assign P = A * B;

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one combinational multiplier between two valid/ready requesters.
// Tie policy selectable via MULT_SHARE_FIXED_PRIO_EN (see mult_share_arb).
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int W  = mult_share_pkg::W,
  parameter int PW = mult_share_pkg::PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_a,
  input  logic [W-1:0]  req0_b,
  output logic          res0_valid,
  input  logic          res0_ready,
  output logic [PW-1:0] res0_p,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_a,
  input  logic [W-1:0]  req1_b,
  output logic          res1_valid,
  input  logic          res1_ready,
  output logic [PW-1:0] res1_p,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0] p_q, p_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          grant;
  logic [PW-1:0] mult_p;

  mult_share_arb u_arb (
    .v0_i    (req0_valid),
    .v1_i    (req1_valid),
    .last_i  (last_q),
    .grant_o (grant)
  );

  multiplier u_mult (
    .P (mult_p),
    .A (a_q),
    .B (b_q)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    p_d        = p_q;
    owner_d    = owner_q;
    last_d     = last_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = !rst && (grant == REQ0) && req0_valid;
        req1_ready = !rst && (grant == REQ1) && req1_valid;
        if (req0_ready || req1_ready) begin
          a_d     = (grant == REQ1) ? req1_a : req0_a;
          b_d     = (grant == REQ1) ? req1_b : req0_b;
          owner_d = grant;
          state_d = MUL;
        end
      end
      MUL: begin
        p_d     = mult_p;
        state_d = HOLD;
      end
      HOLD: begin
        if ((owner_q == REQ1) ? res1_ready : res0_ready) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      owner_q <= REQ0;
      last_q  <= REQ1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Product goes to both channels; only the owner's valid qualifies it.
  assign res0_valid = (state_q == HOLD) && (owner_q == REQ0);
  assign res1_valid = (state_q == HOLD) && (owner_q == REQ1);
  assign res0_p     = p_q;
  assign res1_p     = p_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl: directed scenarios plus random
// traffic against a transaction-level reference model.
module tb_mult_share_ctrl;

  logic       clk, rst;
  logic       req0_valid, req0_ready, res0_valid, res0_ready;
  logic [3:0] req0_a, req0_b;
  logic [7:0] res0_p;
  logic       req1_valid, req1_ready, res1_valid, res1_ready;
  logic [3:0] req1_a, req1_b;
  logic [7:0] res1_p;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  mult_share_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_p(res0_p),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_p(res1_p),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    req0_valid = 0; req0_a = 0; req0_b = 0; res0_ready = 1;
    req1_valid = 0; req1_a = 0; req1_b = 0; res1_ready = 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; drive_idle();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; drive_idle();
    req0_valid = 1; req1_valid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b exp 00", {req0_ready, req1_ready}); end
    n_cmp++; if ({res0_valid, res1_valid} !== 2'b00) begin n_err++; $display("FAIL reset_res_valid: got %b exp 00", {res0_valid, res1_valid}); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_cmp++; if ({res0_p, res1_p} !== 16'h0) begin n_err++; $display("FAIL reset_p: got %h exp 0000", {res0_p, res1_p}); end
    @(posedge clk); #1;
    rst = 0; drive_idle();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy: got %b exp 0", busy); end
  endtask

  task automatic test_basic();
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 3; req0_b = 5; res0_ready = 1;
    @(negedge clk);
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL basic_ready_T: got %b exp 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 0;
    @(negedge clk);
    n_cmp++; if ({busy, res0_valid} !== 2'b10) begin n_err++; $display("FAIL basic_T1: busy,res0_valid got %b exp 10", {busy, res0_valid}); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if ({res0_valid, res1_valid} !== 2'b10) begin n_err++; $display("FAIL basic_T2_valid: got %b exp 10", {res0_valid, res1_valid}); end
    n_cmp++; if (res0_p !== 8'd15) begin n_err++; $display("FAIL basic_T2_p: got %0d exp 15", res0_p); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if ({busy, res0_valid} !== 2'b00) begin n_err++; $display("FAIL basic_T3: busy,res0_valid got %b exp 00", {busy, res0_valid}); end
  endtask

  task automatic test_both();
    int hs_who[$];
    int res_who[$];
    logic [7:0] res_p[$];
    int overlap = 0;
    bit h0, h1;
    do_reset();
    req0_valid = 1; req0_a = 7;  req0_b = 8;
    req1_valid = 1; req1_a = 15; req1_b = 15;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      if (h0) hs_who.push_back(0);
      if (h1) hs_who.push_back(1);
      if (res0_valid && res1_valid) overlap++;
      if (res0_valid && res0_ready) begin res_who.push_back(0); res_p.push_back(res0_p); end
      if (res1_valid && res1_ready) begin res_who.push_back(1); res_p.push_back(res1_p); end
      @(posedge clk); #1;
      if (h0) req0_valid = 0;
      if (h1) req1_valid = 0;
    end
    n_cmp++; if (overlap !== 0) begin n_err++; $display("FAIL both_overlap: got %0d exp 0", overlap); end
    n_cmp++;
    if (hs_who.size() != 2 || res_who.size() != 2) begin
      n_err++; $display("FAIL both_count: hs %0d res %0d exp 2 2", hs_who.size(), res_who.size());
    end else begin
      if (hs_who[0] != 0 || hs_who[1] != 1) begin n_err++; $display("FAIL both_order: got %0d,%0d exp 0,1", hs_who[0], hs_who[1]); end
      n_cmp++;
      if (res_who[0] != 0 || res_p[0] !== 8'd56) begin n_err++; $display("FAIL both_res0: who %0d p %0d exp 0 56", res_who[0], res_p[0]); end
      n_cmp++;
      if (res_who[1] != 1 || res_p[1] !== 8'd225) begin n_err++; $display("FAIL both_res1: who %0d p %0d exp 1 225", res_who[1], res_p[1]); end
    end
  endtask

  task automatic test_alternate();
    int who[$];
    int at[$];
    bit h0, h1;
    do_reset();
    req0_valid = 1; req0_a = 4'($urandom); req0_b = 4'($urandom);
    req1_valid = 1; req1_a = 4'($urandom); req1_b = 4'($urandom);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      if (h0) begin who.push_back(0); at.push_back(c); end
      if (h1) begin who.push_back(1); at.push_back(c); end
      @(posedge clk); #1;
      if (h0) begin req0_a = 4'($urandom); req0_b = 4'($urandom); end
      if (h1) begin req1_a = 4'($urandom); req1_b = 4'($urandom); end
    end
    n_cmp++; if (who.size() != 10) begin n_err++; $display("FAIL alt_count: got %0d exp 10", who.size()); end
    for (int i = 0; i < who.size(); i++) begin
`ifdef MULT_SHARE_FIXED_PRIO_EN
      n_cmp++; if (who[i] != 0) begin n_err++; $display("FAIL alt_grant[%0d]: got %0d exp 0", i, who[i]); end
`else
      n_cmp++; if (who[i] != i % 2) begin n_err++; $display("FAIL alt_grant[%0d]: got %0d exp %0d", i, who[i], i % 2); end
`endif
      if (i > 0) begin
        n_cmp++; if (at[i] - at[i-1] != 3) begin n_err++; $display("FAIL alt_interval[%0d]: got %0d exp 3", i, at[i] - at[i-1]); end
      end
    end
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_hold();
    do_reset();
    res0_ready = 1; res1_ready = 0;
    req1_valid = 1; req1_a = 9; req1_b = 9;
    @(negedge clk);
    n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL hold_grant1: got %b exp 1", req1_ready); end
    @(posedge clk); #1;
    req1_valid = 0; req0_valid = 1; req0_a = 2; req0_b = 2;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({res1_valid, res0_valid, busy, req0_ready} !== 4'b1010 || res1_p !== 8'd81) begin
        n_err++;
        $display("FAIL hold_stall[%0d]: res1_v,res0_v,busy,req0_rdy got %b p %0d exp 1010 p 81",
                 c, {res1_valid, res0_valid, busy, req0_ready}, res1_p);
      end
      @(posedge clk); #1;
    end
    res1_ready = 1;
    @(negedge clk);
    n_cmp++; if ({res1_valid, req0_ready} !== 2'b10) begin n_err++; $display("FAIL hold_release: res1_v,req0_rdy got %b exp 10", {res1_valid, req0_ready}); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL hold_next_grant: got %b exp 1", req0_ready); end
    @(posedge clk); #1;
    req0_valid = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    do_reset();
    req0_valid = 1; req0_a = 6; req0_b = 6;
    @(negedge clk);
    n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_grant: got %b exp 1", req0_ready); end
    @(posedge clk); #1;
    req0_valid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    n_cmp++;
    if ({res0_valid, res1_valid, busy} !== 3'b000 || {res0_p, res1_p} !== 16'h0) begin
      n_err++; $display("FAIL rstmid_outputs: v0,v1,busy got %b p %h exp 000 p 0000", {res0_valid, res1_valid, busy}, {res0_p, res1_p});
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (res0_valid || res1_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rstmid_no_result: got %0d result cycles exp 0", seen); end
  endtask

  // Transaction-level model: one op outstanding, result visible two cycles
  // after its handshake, next grant the cycle after the result is taken.
  task automatic test_random();
    bit outst = 0, own = 0, last_m = 1;
    logic [7:0] prod = 0;
    int hs_cyc = 0, free_at = 0;
    bit h0 = 0, h1 = 0;
    bit e_g, e_r0, e_r1, e_v0, e_v1;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      if (!req0_valid || h0) begin req0_valid = 1'($urandom_range(0, 1)); req0_a = 4'($urandom); req0_b = 4'($urandom); end
      if (!req1_valid || h1) begin req1_valid = 1'($urandom_range(0, 1)); req1_a = 4'($urandom); req1_b = 4'($urandom); end
      res0_ready = ($urandom_range(0, 3) != 0);
      res1_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
`ifdef MULT_SHARE_FIXED_PRIO_EN
      e_g = (req0_valid && req1_valid) ? 1'b0 : req1_valid;
`else
      e_g = (req0_valid && req1_valid) ? !last_m : req1_valid;
`endif
      e_r0 = !outst && cyc >= free_at && req0_valid && !e_g;
      e_r1 = !outst && cyc >= free_at && req1_valid && e_g;
      e_v0 = outst && !own && cyc >= hs_cyc + 2;
      e_v1 = outst &&  own && cyc >= hs_cyc + 2;
      n_cmp++;
      if ({req0_ready, req1_ready} !== {e_r0, e_r1}) begin n_err++; $display("FAIL rnd_ready@%0d: got %b exp %b", cyc, {req0_ready, req1_ready}, {e_r0, e_r1}); end
      n_cmp++;
      if ({res0_valid, res1_valid, busy} !== {e_v0, e_v1, outst}) begin n_err++; $display("FAIL rnd_valid_busy@%0d: got %b exp %b", cyc, {res0_valid, res1_valid, busy}, {e_v0, e_v1, outst}); end
      if (e_v0 || e_v1) begin
        n_cmp++;
        if ((e_v0 ? res0_p : res1_p) !== prod) begin n_err++; $display("FAIL rnd_product@%0d: got %0d exp %0d", cyc, e_v0 ? res0_p : res1_p, prod); end
      end
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      if (e_r0 || e_r1) begin
        outst = 1; own = e_r1; hs_cyc = cyc;
        prod = e_r1 ? req1_a * req1_b : req0_a * req0_b;
      end else if ((e_v0 && res0_ready) || (e_v1 && res1_ready)) begin
        outst = 0; last_m = own; free_at = cyc + 1;
      end
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_both();
    test_alternate();
    test_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
